// File: rtl/fft_stream_pkg.sv
// fft_stream_pkg: shared constants and types for the FFT frame streamer.
package fft_stream_pkg;

   localparam int unsigned N_DEFAULT = 1024;
   localparam int unsigned IDX_W     = $clog2(N_DEFAULT);
   localparam int unsigned DATA_W    = 16;

   typedef enum logic [1:0] {
      IDLE,
      PREFETCH,
      STREAM
   } rd_state_t;

   typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/dstream.sv
// dstream: valid/ready stream carrying a data word and its frame index.
interface dstream #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = fft_stream_pkg::IDX_W
);

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [IDX_W-1:0]  index;

   modport out (output valid, output data, output index, input ready);
   modport in  (input valid, input data, input index, output ready);

endinterface

// File: rtl/fft_frame_streamer_ram.sv
// ping_pong_ram: simple dual-port 2*N x DATA_W store, address {bank, ptr},
// registered one-cycle read. The read register holds when rd_en is low and
// clears on reset so the streamed data word starts at zero.
module ping_pong_ram #(
   parameter int unsigned N      = 1024,
   parameter int unsigned DATA_W = 16,
   localparam int unsigned AW    = $clog2(2 * N)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2*N];

   // write port, contents are never reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // registered read port with enable so a stalled beat stays stable
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: gathers strobed PCM samples into N-sample frames in a
// ping-pong RAM and replays each full frame on a dstream port with index
// 0..N-1. Samples arriving while both banks are full are dropped and counted.
// Build option FFT_FRAME_WINDOW_EN: apply a triangular window through one
// extra output register stage.
module fft_frame_streamer #(
   parameter int unsigned N      = fft_stream_pkg::N_DEFAULT,
   parameter int unsigned DATA_W = fft_stream_pkg::DATA_W,
   parameter int unsigned OUT_W  = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     sample_valid,
   input  logic signed [DATA_W-1:0] sample_data,
   dstream.out                      fft_in,
   output logic [15:0]              frames_sent,
   output logic [15:0]              overflow_count,
   output logic                     overflow
);

   import fft_stream_pkg::*;

   localparam int unsigned AW       = $clog2(N);
   localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

   rd_state_t                state, nstate;
   logic [1:0]               full;
   logic                     wr_bank;
   logic [AW-1:0]            wr_ptr;
   logic                     wr_free, we, drop, wr_last;
   logic                     rd_bank, rd_bank_n;
   logic [AW-1:0]            idx, idx_n, idx_inc;
   logic                     rd_en, clr_full;
   logic [AW:0]              rd_addr;
   logic                     beat_valid, beat_ready, take;
   logic signed [DATA_W-1:0] rd_sample;
   logic                     out_valid;
   logic [AW-1:0]            out_idx;
   logic signed [DATA_W-1:0] out_sample;

   ping_pong_ram #(
      .N      (N),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (we),
      .wr_addr ({wr_bank, wr_ptr}),
      .wr_data (sample_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_sample)
   );

   // write-side decode; a bank released by the reader this cycle counts as free
   always_comb begin
      wr_free = !full[wr_bank] || (clr_full && (rd_bank == wr_bank));
      we      = sample_valid && wr_free;
      drop    = sample_valid && !wr_free;
      wr_last = (wr_ptr == IDX_LAST);
   end

   // write pointer and bank select
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_bank <= 1'b0;
         wr_ptr  <= '0;
      end else if (we) begin
         if (wr_last) begin
            wr_ptr  <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_ptr <= wr_ptr + AW'(1);
         end
      end
   end

   // bank-full flags: set by the writer on the last sample, cleared by the reader
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         full <= '0;
      end else begin
         if (clr_full) begin
            full[rd_bank] <= 1'b0;
         end
         if (we && wr_last) begin
            full[wr_bank] <= 1'b1;
         end
      end
   end

   // drop counter (saturating) and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow_count <= '0;
         overflow       <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (overflow_count != 16'hFFFF) begin
            overflow_count <= overflow_count + 16'd1;
         end
      end
   end

   assign beat_valid = (state == STREAM);
   assign take       = beat_valid && beat_ready;
   assign idx_inc    = idx + AW'(1);

   // read FSM next state, RAM read request and frame release
   always_comb begin
      nstate    = state;
      idx_n     = idx;
      rd_bank_n = rd_bank;
      rd_en     = 1'b0;
      rd_addr   = {rd_bank, AW'(0)};
      clr_full  = 1'b0;
      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               nstate = PREFETCH;
            end
         end
         PREFETCH: begin
            rd_en  = 1'b1;
            idx_n  = '0;
            nstate = STREAM;
         end
         STREAM: begin
            if (take) begin
               if (idx == IDX_LAST) begin
                  clr_full  = 1'b1;
                  rd_bank_n = ~rd_bank;
                  idx_n     = '0;
                  nstate    = full[~rd_bank] ? PREFETCH : IDLE;
               end else begin
                  idx_n   = idx_inc;
                  rd_en   = 1'b1;
                  rd_addr = {rd_bank, idx_inc};
               end
            end
         end
         default: nstate = IDLE;
      endcase
   end

   // read FSM state, index and bank registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         idx     <= '0;
         rd_bank <= 1'b0;
      end else begin
         state   <= nstate;
         idx     <= idx_n;
         rd_bank <= rd_bank_n;
      end
   end

`ifdef FFT_FRAME_WINDOW_EN
   localparam int unsigned PW = DATA_W + AW;

   logic [AW-1:0]            coef;
   logic signed [PW-1:0]     prod;
   logic signed [DATA_W-1:0] win_sample;

   // triangular coefficient and scaled product for the beat leaving the RAM
   always_comb begin
      coef       = (idx < AW'(N / 2)) ? idx : (IDX_LAST - idx);
      prod       = PW'(rd_sample) * signed'(PW'(coef));
      win_sample = DATA_W'(prod >>> (AW - 1));
   end

   // RAM beat advances into the output stage whenever that stage is empty or drains
   assign beat_ready = !out_valid || fft_in.ready;

   // output pipeline register holding windowed data and index
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_sample <= '0;
      end else if (beat_ready) begin
         out_valid <= beat_valid;
         if (beat_valid) begin
            out_idx    <= idx;
            out_sample <= win_sample;
         end
      end
   end
`else
   assign beat_ready = fft_in.ready;
   assign out_valid  = beat_valid;
   assign out_idx    = idx;
   assign out_sample = rd_sample;
`endif

   assign fft_in.valid = out_valid;
   assign fft_in.index = out_idx;
   assign fft_in.data  = OUT_W'(out_sample);

   // count frames whose last beat has been accepted downstream
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frames_sent <= '0;
      end else if (out_valid && fft_in.ready && (out_idx == IDX_LAST)) begin
         frames_sent <= frames_sent + 16'd1;
      end
   end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb_fft_frame_streamer: directed bench for fft_frame_streamer at N=16.
module tb_fft_frame_streamer;

   import fft_stream_pkg::*;

   localparam int unsigned TB_N   = 16;
   localparam int unsigned TB_DW  = 16;
   localparam int unsigned TB_OW  = 32;
`ifdef FFT_FRAME_WINDOW_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic    clk;
   logic    reset_n;
   logic    sample_valid;
   sample_t sample_data;
   logic [15:0] frames_sent;
   logic [15:0] overflow_count;
   logic        overflow;

   int pass_cnt;
   int fail_cnt;
   int chk_cnt;

   dstream #(.DATA_W(TB_OW), .IDX_W(4)) fft_in_if ();

   fft_frame_streamer #(
      .N      (TB_N),
      .DATA_W (TB_DW),
      .OUT_W  (TB_OW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sample_valid   (sample_valid),
      .sample_data    (sample_data),
      .fft_in         (fft_in_if),
      .frames_sent    (frames_sent),
      .overflow_count (overflow_count),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input int d);
      sample_valid = 1'b1;
      sample_data  = sample_t'(d);
      tick();
      sample_valid = 1'b0;
   endtask

   // expected output word for sample s at frame position idx
   function automatic logic [31:0] exp_data(input int s, input int idx);
      logic signed [15:0] t;
`ifdef FFT_FRAME_WINDOW_EN
      int c;
      int p;
      c = (idx < 8) ? idx : 15 - idx;
      p = (s * c) >>> 3;
      t = 16'(p);
`else
      t = 16'(s);
`endif
      return 32'(t);
   endfunction

   // wait (bounded) for a frame, then take 16 beats with ready held high
   task automatic stream_frame(input string tag, input int base);
      int n;
      n = 0;
      fft_in_if.ready = 1'b1;
      while (!fft_in_if.valid && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_start_valid"}, 32'(fft_in_if.valid), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk({tag, "_index"}, 32'(fft_in_if.index), 32'(i));
         chk({tag, "_data"}, fft_in_if.data, exp_data(base + i, i));
         tick();
      end
      chk({tag, "_end_valid"}, 32'(fft_in_if.valid), 32'd0);
   endtask

   initial begin
      logic [3:0] pat;
      int got;
      int cyc;

      pass_cnt = 0;
      fail_cnt = 0;
      chk_cnt  = 0;
      reset_n         = 1'b0;
      sample_valid    = 1'b0;
      sample_data     = '0;
      fft_in_if.ready = 1'b1;
      tick();
      tick();

      // reset state
      chk("rst_valid", 32'(fft_in_if.valid), 32'd0);
      chk("rst_index", 32'(fft_in_if.index), 32'd0);
      chk("rst_data", fft_in_if.data, 32'd0);
      chk("rst_frames", 32'(frames_sent), 32'd0);
      chk("rst_ovc", 32'(overflow_count), 32'd0);
      chk("rst_ov", 32'(overflow), 32'd0);
      reset_n = 1'b1;
      tick();

      // frame 0..15, ready high, first beat LAT cycles after the last strobe
      for (int i = 0; i < 16; i++) strobe(i);
      chk("t1_lat0", 32'(fft_in_if.valid), 32'd0);
      for (int k = 1; k < LAT; k++) begin
         tick();
         chk("t1_lat_early", 32'(fft_in_if.valid), 32'd0);
      end
      tick();
      chk("t1_lat_first", 32'(fft_in_if.valid), 32'd1);
      stream_frame("t1", 0);
      chk("t1_frames", 32'(frames_sent), 32'd1);

      // same frame with ready cycling 1,0,0,1: stalled beats must hold
      for (int i = 0; i < 16; i++) strobe(i);
      pat = 4'b1001;
      got = 0;
      cyc = 0;
      while (got < 16 && cyc < 120) begin
         fft_in_if.ready = pat[cyc % 4];
         if (fft_in_if.valid) begin
            chk("t2_index", 32'(fft_in_if.index), 32'(got));
            chk("t2_data", fft_in_if.data, exp_data(got, got));
            if (fft_in_if.ready) got++;
         end
         tick();
         cyc++;
      end
      chk("t2_accepted", 32'(got), 32'd16);
      chk("t2_frames", 32'(frames_sent), 32'd2);
      fft_in_if.ready = 1'b1;
      tick();
      chk("t2_idle", 32'(fft_in_if.valid), 32'd0);

      // ready low, 40 strobes: 32 buffered, 8 dropped
      fft_in_if.ready = 1'b0;
      for (int i = 0; i < 40; i++) strobe(100 + i);
      tick();
      chk("t3_ovc", 32'(overflow_count), 32'd8);
      chk("t3_ov", 32'(overflow), 32'd1);
      chk("t3_valid", 32'(fft_in_if.valid), 32'd1);
      chk("t3_index", 32'(fft_in_if.index), 32'd0);
      chk("t3_data", fft_in_if.data, exp_data(100, 0));

      // release: strobe lands on the cycle the last beat of bank 0 is accepted
      fft_in_if.ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t3a_index", 32'(fft_in_if.index), 32'(i));
         chk("t3a_data", fft_in_if.data, exp_data(100 + i, i));
         if (i == 15) begin
            sample_valid = 1'b1;
            sample_data  = sample_t'(555);
         end
         tick();
         sample_valid = 1'b0;
      end
      chk("t3_sim_ovc", 32'(overflow_count), 32'd8);
      stream_frame("t3b", 116);
      chk("t3_frames", 32'(frames_sent), 32'd4);
      for (int i = 1; i < 16; i++) strobe(555 + i);
      stream_frame("t3c", 555);
      chk("t3c_frames", 32'(frames_sent), 32'd5);
      chk("t3c_ovc", 32'(overflow_count), 32'd8);

      // reset at index 7 mid-stream, then a clean frame (negative samples too)
      for (int i = 0; i < 16; i++) strobe(-8 + i);
      fft_in_if.ready = 1'b1;
      cyc = 0;
      while (!(fft_in_if.valid && fft_in_if.index == 4'd7) && cyc < 60) begin
         tick();
         cyc++;
      end
      chk("t4_reached7", 32'(fft_in_if.index), 32'd7);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t4_valid", 32'(fft_in_if.valid), 32'd0);
      chk("t4_index", 32'(fft_in_if.index), 32'd0);
      chk("t4_data", fft_in_if.data, 32'd0);
      chk("t4_frames", 32'(frames_sent), 32'd0);
      chk("t4_ovc", 32'(overflow_count), 32'd0);
      chk("t4_ov", 32'(overflow), 32'd0);
      tick();
      chk("t4_still_idle", 32'(fft_in_if.valid), 32'd0);
      for (int i = 0; i < 16; i++) strobe(-8 + i);
      stream_frame("t4b", -8);
      chk("t4b_frames", 32'(frames_sent), 32'd1);

`ifdef FFT_FRAME_WINDOW_EN
      // constant 1000 input: 0,125,...,875,875,...,125,0
      for (int i = 0; i < 16; i++) strobe(1000);
      stream_frame("win", 1000);
      chk("win_frames", 32'(frames_sent), 32'd2);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
- Source end of the dstream FFT interface. Collects microphone PCM samples, arriving as a single-cycle strobe with no backpressure, into frames of N samples.
- Replays each complete frame on a dstream.out port with index 0..N-1, honouring ready.
- Ping-pong buffering lets the next frame fill while the current frame streams. Drops and counts samples when both banks are busy.
- Sits between the microphone/ADC sample path and the FFT core input.

Parameters:
- N, 1024, frame length in samples; power of two, at least 8.
- DATA_W, 16, signed input sample width.
- OUT_W, 32, width of fft_in.data; must be at least DATA_W; samples are sign-extended.

Ports:
- clk  input  1  single clock for all logic.
- reset_n  input  1  synchronous, active-low reset.
- sample_valid  input  1  one-cycle strobe; a new sample is present.
- sample_data  input  DATA_W  signed PCM sample, qualified by sample_valid.
- fft_in  dstream.out  -  frame output stream; fields valid (out), ready (in), data OUT_W (out), index $clog2(N) (out).
- frames_sent  output  16  count of fully accepted frames; wraps.
- overflow_count  output  16  dropped samples; saturates at 16'hFFFF.
- overflow  output  1  sticky; set on the first drop, cleared only by reset.

Behaviour:
- Reset is synchronous and active-low.
  - While reset_n is 0, at each clk edge: fft_in.valid=0, fft_in.index=0, fft_in.data=0, frames_sent=0, overflow_count=0, overflow=0.
  - Both bank-full flags are cleared; wr_bank=0, rd_bank=0, wr_ptr=0.
  - RAM contents are not reset.
  - Reset mid-frame discards both partial and full frames with no output glitch; valid is 0 the cycle after reset.
- Write side:
  - A strobe writes to bank wr_bank at address wr_ptr, then wr_ptr increments.
  - At wr_ptr=N-1 the write sets full[wr_bank], toggles wr_bank and sets wr_ptr to 0.
  - If full[wr_bank] is set, the sample is dropped, overflow_count increments (saturating), overflow is set, and wr_ptr holds.
  - Simultaneous event: if the reader clears full[wr_bank] in the same cycle a strobe arrives, the bank counts as free and the sample is written.
- Read FSM states:
  - IDLE -> PREFETCH when full[rd_bank]=1.
  - PREFETCH: issue RAM read of address 0 (1-cycle read latency) -> STREAM.
  - STREAM: the output register holds data/index and valid=1.
    - While valid & !ready, data and index are held stable.
    - On valid & ready, the next address is presented so a new beat is ready the next cycle. Throughput is 1 beat/cycle with ready high.
  - On acceptance of index N-1: clear full[rd_bank], toggle rd_bank, increment frames_sent, set index to 0.
    - If full on the new rd_bank is set, go to PREFETCH; otherwise go to IDLE with valid=0.
- Latency: first beat valid 2 cycles after the full flag sets; 3 cycles with WINDOW_EN.
- index is the RAM read address, so an accepted stream is always 0..N-1 in order, with no gaps or repeats.
- fft_in.data is sample_data sign-extended to OUT_W.
- A bank is never written while its full flag is set, so streamed data are never overwritten.

Optional Feature:
- Macro FFT_FRAME_WINDOW_EN.
- Defined: apply a triangular window before output.
  - c = (idx < N/2) ? idx : N-1-idx.
  - out = (sample * c) >>> ($clog2(N)-1), computed at DATA_W+$clog2(N) bits, truncated to DATA_W, then sign-extended to OUT_W.
  - Adds one pipeline register; the hold-on-!ready rule applies to every stage.
- Undefined: raw samples, 2-cycle latency, no multiplier.

Decomposition:
- Package fft_stream_pkg: localparams N_DEFAULT, IDX_W=$clog2(N), DATA_W; typedef enum rd_state_t {IDLE, PREFETCH, STREAM}; typedef sample_t logic signed [DATA_W-1:0].
- Sub-module ping_pong_ram: simple dual-port, 2*N x DATA_W, address {bank, ptr}, registered 1-cycle read. It infers block RAM.
- FSM, counters and window stay in fft_frame_streamer.

Test Plan:
- N=16, 16 strobes with data 0..15, ready=1 -> 16 beats on consecutive cycles, index 0..15, data 0..15; frames_sent=1; first valid 2 cycles after the 16th strobe.
- Same frame with ready toggling 1,0,0,1 -> data/index stable while stalled; accepted sequence still 0..15, no duplicates.
- ready=0 held, 40 strobes -> 32 samples buffered, 8 dropped; overflow_count=8; overflow=1; releasing ready streams frames 0..15 then 16..31, frames_sent=2.
- Reader frees a bank on the same cycle a strobe arrives with the other bank full -> sample written, overflow_count unchanged.
- reset_n=0 for 1 cycle at mid-stream index 7 -> valid=0 next cycle, counters 0; the next 16 strobes produce a clean frame starting at index 0.
- WINDOW_EN, N=16, all samples 16'sd1000 -> data = 1000*c>>>3 for c=0..7,7..0, i.e. 0,125,250,...,875,875,...,0.
